fetch_ctrl: RTL
===============

# fetch_ctrl

Sequencing controller for the fetch-stage PC register. It generates the PC write enable and next-PC source select, and arbitrates between sequential fetch, decode-stage jumps, and execute-stage branch/jr redirects. When instruction memory is busy, it buffers a pending redirect until memory completes. It also raises the pipeline flush and hold requests and latches processor halt. It sits between the hazard/branch logic and the PC register in the fetch stage.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters (used only with FETCH_PERF_EN).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  instruction memory has returned the word at the current PC this cycle.
- stall  in  1  decode-stage hazard stall; the IF/ID latch must not advance.
- br_taken  in  1  execute-stage conditional branch resolved taken.
- jr_ex  in  1  execute-stage jr; jraddr valid.
- j_id  in  1  decode-stage j/jal; jaddr valid.
- halt  in  1  halt instruction has reached writeback.
- pcen  out  1  PC register write enable.
- PCSrc  out  2  next-PC select: 0 = PC+4, 1 = jr, 2 = j, 3 = branch.
- iren  out  1  instruction memory read enable.
- flush_ifid  out  1  clear the IF/ID latch on the next edge.
- flush_idex  out  1  clear the ID/EX latch on the next edge.
- redir_hold  out  1  freeze pipeline latches up to and including the redirect source stage.
- halted  out  1  processor halted.
- fetch_cnt  out  CNT_W  instructions fetched (FETCH_PERF_EN only).
- stall_cnt  out  CNT_W  fetch stall cycles (FETCH_PERF_EN only).

## Operation
- States: RUN, WAIT_REDIR, HALT. The reset state is RUN, and the latched source sel_q resets to 0.
- Redirect priority: halt > execute redirect (br_taken→3, jr_ex→1; both asserted → 1) > j_id (→2) > sequential (→0).
- RUN state:
  - If halt: go to HALT; pcen=0.
  - If an execute redirect and ihit: pcen=1, PCSrc=src, flush_ifid=1, flush_idex=1; the redirect overrides stall.
  - If an execute redirect and !ihit: latch sel_q=src, set ex_q=1, go to WAIT_REDIR; pcen=0, redir_hold=1.
  - Else if j_id and !stall: with ihit, pcen=1, PCSrc=2, flush_ifid=1. Without ihit, latch sel_q=2, ex_q=0, go to WAIT_REDIR, redir_hold=1.
  - Else: pcen = ihit & !stall, PCSrc=0.
- WAIT_REDIR state:
  - PCSrc=sel_q and redir_hold=1.
  - Inputs br_taken, jr_ex, j_id and stall are ignored, because the source stage is frozen.
  - On ihit: pcen=1, flush_ifid=1, flush_idex=ex_q, go to RUN.
  - halt takes precedence: go to HALT without committing the redirect.
- HALT state: pcen=0, iren=0, halted=1, all flushes 0. The block leaves HALT only on reset.
- iren=1 in RUN and WAIT_REDIR.
- A j_id that arrives while stall is asserted is not acted on; it is re-presented when stall drops.

## Timing
- pcen, PCSrc, flush_ifid, flush_idex and redir_hold are combinational (Mealy) from the state and the current inputs. The PC updates on the same rising edge that samples pcen=1.
- halted is registered: it asserts the cycle after halt is sampled in RUN or WAIT_REDIR.
- Redirect latency: zero cycles with ihit; with imem busy, the redirect commits in the first cycle ihit=1.
- Output values during reset: pcen=0, PCSrc=0, iren=0, flushes=0, redir_hold=0, halted=0, counters=0.
- Reset asserted mid-WAIT_REDIR discards the pending redirect and returns the block to RUN.

## Configuration
- FETCH_PERF_EN defined:
  - fetch_cnt increments on every cycle with pcen=1.
  - stall_cnt increments on every cycle in RUN or WAIT_REDIR with pcen=0.
  - Both counters saturate at all-ones and freeze in HALT.
- FETCH_PERF_EN undefined: the counter ports and registers are absent; all other behaviour is identical.

## Test plan
- Sequential: ihit=1 and no events for 4 cycles → pcen=1 and PCSrc=0 every cycle; PC goes 0,4,8,12,16.
- Branch with memory busy: br_taken=1 with ihit=0 → redir_hold=1 and PCSrc=3 for 3 cycles. When ihit=1: pcen=1, flush_ifid=1, flush_idex=1, then back to RUN.
- Collision: br_taken=1, j_id=1 and stall=1 in the same cycle with ihit=1 → PCSrc=3, pcen=1, both flushes asserted, and the jump is dropped.
- Stalled jump: j_id=1 with stall=1 for 2 cycles → pcen=0. stall then drops with ihit=1 → PCSrc=2, pcen=1, flush_ifid=1, flush_idex=0.
- Halt mid-wait: jr_ex=1 with ihit=0, then halt=1 → pcen stays 0, halted=1 the next cycle, iren=0 from then on. nRST pulse → RUN and halted=0.
- FETCH_PERF_EN: 5 fetches and 3 ihit=0 cycles → fetch_cnt=5, stall_cnt=3. With CNT_W=4, 20 fetches → fetch_cnt=15.

Source files
------------

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Fetch-stage PC sequencing: redirect arbitration, pending-redirect
//            buffering while imem is busy, flush/hold requests, halt latch.
//            Optional macro FETCH_PERF_EN adds fetch/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             stall,
    input  logic             br_taken,
    input  logic             jr_ex,
    input  logic             j_id,
    input  logic             halt,
    output logic             pcen,
    output logic [1:0]       PCSrc,
    output logic             iren,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             redir_hold,
    output logic             halted
`ifdef FETCH_PERF_EN
    ,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT_REDIR = 2'd1,
        HALT       = 2'd2
    } state_t;

    state_t     r_state, w_next;
    logic [1:0] r_sel, w_sel;
    logic       r_ex, w_ex_n;
    logic       w_pcen, w_flush_ifid, w_flush_idex, w_hold;
    logic [1:0] w_src;
    logic       w_ex_redir;
    logic [1:0] w_ex_src;

    assign w_ex_redir = br_taken | jr_ex;
    assign w_ex_src   = jr_ex ? 2'd1 : 2'd3;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= RUN;
            r_sel   <= 2'd0;
            r_ex    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sel   <= w_sel;
            r_ex    <= w_ex_n;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_sel        = r_sel;
        w_ex_n       = r_ex;
        w_pcen       = 1'b0;
        w_src        = 2'd0;
        w_flush_ifid = 1'b0;
        w_flush_idex = 1'b0;
        w_hold       = 1'b0;
        unique case (r_state)
            RUN: begin
                if (halt) begin
                    w_next = HALT;
                end else if (w_ex_redir) begin
                    // Execute redirect wins over stall and any decode jump
                    w_src = w_ex_src;
                    if (ihit) begin
                        w_pcen       = 1'b1;
                        w_flush_ifid = 1'b1;
                        w_flush_idex = 1'b1;
                    end else begin
                        w_sel  = w_ex_src;
                        w_ex_n = 1'b1;
                        w_hold = 1'b1;
                        w_next = WAIT_REDIR;
                    end
                end else if (j_id && !stall) begin
                    w_src = 2'd2;
                    if (ihit) begin
                        w_pcen       = 1'b1;
                        w_flush_ifid = 1'b1;
                    end else begin
                        w_sel  = 2'd2;
                        w_ex_n = 1'b0;
                        w_hold = 1'b1;
                        w_next = WAIT_REDIR;
                    end
                end else begin
                    w_pcen = ihit & ~stall;
                end
            end
            WAIT_REDIR: begin
                // Source stage is frozen, so new redirects and stall are ignored
                w_src  = r_sel;
                w_hold = 1'b1;
                if (halt) begin
                    w_next = HALT;
                end else if (ihit) begin
                    w_pcen       = 1'b1;
                    w_flush_ifid = 1'b1;
                    w_flush_idex = r_ex;
                    w_next       = RUN;
                end
            end
            HALT: begin
                w_next = HALT;
            end
            default: begin
                w_next = RUN;
            end
        endcase
    end

    // Outputs are forced quiet while reset is asserted
    assign pcen       = nRST & w_pcen;
    assign PCSrc      = nRST ? w_src : 2'd0;
    assign flush_ifid = nRST & w_flush_ifid;
    assign flush_idex = nRST & w_flush_idex;
    assign redir_hold = nRST & w_hold;
    assign iren       = nRST & (r_state != HALT);
    assign halted     = (r_state == HALT);

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] r_fetch_cnt, r_stall_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (r_state != HALT) begin
            if (w_pcen && (r_fetch_cnt != {CNT_W{1'b1}}))
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
            if (!w_pcen && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    // Counter width only matters when the performance counters are built
    generate
        if (CNT_W < 1) begin : g_cnt_w_unused
        end
    endgenerate
`endif

endmodule
`default_nettype wire
